// File: rtl/io_bank_pkg.sv
// io_bank_pkg
//   Shared types and helpers for the I/O channel bank.
//   - pulse_state_t : pulse-train sequencer states
//   - chan_hit_t    : result of an address decode (hit flag + channel index)
//   - chan_hit()    : decodes a channel address against a base and a channel count
//   - pulse_cnt_w() : width of the half-period counter for a given divider
//   - PULSE_CNT_W   : counter width for the default divider of 16
package io_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pulse_state_t;

  // The index is 4 bits wide because the bank never exceeds 16 channels.
  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } chan_hit_t;

  localparam int PULSE_DIV_DEFAULT = 16;
  localparam int PULSE_CNT_W       = $clog2(PULSE_DIV_DEFAULT);

  // The counter runs 0..div-1; a divider of 1 still needs one bit.
  function automatic int pulse_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic chan_hit_t chan_hit(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          n);
    chan_hit_t  r;
    logic [31:0] off;
    off   = addr - base;
    r.hit = (addr >= base) && (off < 32'(n));
    r.idx = off[3:0];
    return r;
  endfunction

endpackage

// File: rtl/io_pulse_seq.sv
// io_pulse_seq
//   Pulse-train sequencer for one channel of io_channel_bank. It emits
//   PULSE_DIV cycles high followed by PULSE_DIV cycles low per count, and
//   asks the bank to decrement the count register at the end of every low
//   half-period. The count itself lives in the bank's channel register.
//   Ports:
//     clk_i            clock
//     rst_i            asynchronous active-high reset
//     load_i           start a train (count already checked nonzero)
//     abort_i          return to IDLE immediately, no done
//     count_nonzero_i  count will still be nonzero after the pending decrement
//     pulse_o          pulse-train output
//     busy_o           sequencer in HIGH or LOW
//     done_o           one-cycle flag in the first idle cycle after a train
//     dec_o            decrement the count register at this edge
module io_pulse_seq
  import io_bank_pkg::*;
#(
  parameter int PULSE_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic abort_i,
  input  logic count_nonzero_i,
  output logic pulse_o,
  output logic busy_o,
  output logic done_o,
  output logic dec_o
);

  localparam int               CNT_W    = pulse_cnt_w(PULSE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_DIV - 1);

  pulse_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dec_o   = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            state_d = HIGH;
            cnt_d   = '0;
          end
        end
        HIGH: begin
          if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOW: begin
          if (cnt_q == CNT_LAST) begin
            // End of one full period: the bank decrements the count here.
            dec_o = 1'b1;
            cnt_d = '0;
            if (count_nonzero_i) begin
              state_d = HIGH;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Decoded from the state register so an asynchronous reset drops them at once.
  assign pulse_o = (state_q == HIGH);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

endmodule

// File: rtl/io_channel_bank.sv
// io_channel_bank
//   Bank of NCHAN addressable WIDTH-bit output channels on the central
//   channel bus. Channels occupy BASE_ADDR..BASE_ADDR+NCHAN-1. Writes load
//   WL, clears zero a channel, reads return the channel OR-ed with its CHIN
//   slice one cycle later. GOJAM clears every channel.
//   Optional feature macro: IOBANK_PULSE_EN. When defined, channel PULSE_CHAN
//   drives a pulse-train sequencer whose count is the channel register; when
//   undefined that channel is a plain register and the PULSE_* outputs are 0.
//   Ports:
//     SIM_CLK, SIM_RST      clock, asynchronous active-high reset
//     GOJAM                 synchronous restart (clears all, aborts sequencer)
//     CHADDR                channel address
//     RCHG / WCHG / CCHG    read / write / clear strobes
//     WL                    write data
//     CHIN                  external OR inputs, slice i for channel i
//     CH, CH_VALID          registered read data and one-cycle valid
//     CHOUT                 all channel registers, slice i for channel i
//     PULSE, PULSE_BUSY     pulse output and sequencer-active flag
//     PULSE_DONE            one-cycle completion flag
//     PULSE_OVR             sticky flag: write to the pulse channel while busy
module io_channel_bank
  import io_bank_pkg::*;
#(
  parameter int NCHAN      = 4,
  parameter int WIDTH      = 15,
  parameter int ADDRW      = 9,
  parameter int BASE_ADDR  = 'o13,
  parameter int PULSE_CHAN = 1,
  parameter int PULSE_DIV  = 16
) (
  input  logic                   SIM_CLK,
  input  logic                   SIM_RST,
  input  logic                   GOJAM,
  input  logic [ADDRW-1:0]       CHADDR,
  input  logic                   RCHG,
  input  logic                   WCHG,
  input  logic                   CCHG,
  input  logic [WIDTH-1:0]       WL,
  input  logic [NCHAN*WIDTH-1:0] CHIN,
  output logic [WIDTH-1:0]       CH,
  output logic                   CH_VALID,
  output logic [NCHAN*WIDTH-1:0] CHOUT,
  output logic                   PULSE,
  output logic                   PULSE_BUSY,
  output logic                   PULSE_DONE,
  output logic                   PULSE_OVR
);

  if (NCHAN < 1 || NCHAN > 16 || PULSE_DIV < 1 ||
      PULSE_CHAN < 0 || PULSE_CHAN >= NCHAN) begin : g_bad_param
    $error("io_channel_bank: illegal parameter set");
  end

  logic [WIDTH-1:0] chan_q [NCHAN];
  logic [WIDTH-1:0] chan_d [NCHAN];
  logic [WIDTH-1:0] ch_q, ch_d;
  logic             ch_valid_q, ch_valid_d;

  chan_hit_t hit_s;
  logic      wr_hit, clr_hit, rd_hit;
  logic      seq_busy, seq_dec;

  assign hit_s   = chan_hit(32'(CHADDR), 32'(BASE_ADDR), NCHAN);
  assign wr_hit  = WCHG & hit_s.hit;
  assign clr_hit = CCHG & hit_s.hit;
  assign rd_hit  = RCHG & hit_s.hit;

  // Reads see the register before any same-cycle write lands.
  always_comb begin
    ch_d       = '0;
    ch_valid_d = 1'b0;
    if (rd_hit) begin
      ch_valid_d = 1'b1;
      for (int i = 0; i < NCHAN; i++) begin
        if (hit_s.idx == 4'(i)) ch_d = chan_q[i] | CHIN[i*WIDTH +: WIDTH];
      end
    end
  end

  // GOJAM > clear > write. A write to the pulse channel while the sequencer
  // runs is dropped so the remaining count stays intact.
  always_comb begin
    for (int i = 0; i < NCHAN; i++) chan_d[i] = chan_q[i];
    if (GOJAM) begin
      for (int i = 0; i < NCHAN; i++) chan_d[i] = '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (hit_s.idx == 4'(i)) begin
          if (clr_hit)                                     chan_d[i] = '0;
          else if (wr_hit && !(i == PULSE_CHAN && seq_busy)) chan_d[i] = WL;
        end
      end
      // The sequencer only decrements while busy, when pulse-channel writes
      // are ignored and clears abort it, so this never collides.
      if (seq_dec) chan_d[PULSE_CHAN] = chan_q[PULSE_CHAN] - 1'b1;
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      for (int i = 0; i < NCHAN; i++) chan_q[i] <= '0;
      ch_q       <= '0;
      ch_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCHAN; i++) chan_q[i] <= chan_d[i];
      ch_q       <= ch_d;
      ch_valid_q <= ch_valid_d;
    end
  end

  assign CH       = ch_q;
  assign CH_VALID = ch_valid_q;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chout
    assign CHOUT[g*WIDTH +: WIDTH] = chan_q[g];
  end

`ifdef IOBANK_PULSE_EN
  logic pc_sel, seq_load, seq_abort, cnt_nonzero;
  logic ovr_q, ovr_d;

  assign pc_sel    = (hit_s.idx == 4'(PULSE_CHAN));
  assign seq_load  = wr_hit & ~clr_hit & ~GOJAM & pc_sel & ~seq_busy & (WL != '0);
  assign seq_abort = GOJAM | (clr_hit & pc_sel);
  // Tells the sequencer whether the count survives the pending decrement.
  assign cnt_nonzero = (chan_q[PULSE_CHAN] != WIDTH'(1));

  io_pulse_seq #(
    .PULSE_DIV(PULSE_DIV)
  ) u_pulse_seq (
    .clk_i          (SIM_CLK),
    .rst_i          (SIM_RST),
    .load_i         (seq_load),
    .abort_i        (seq_abort),
    .count_nonzero_i(cnt_nonzero),
    .pulse_o        (PULSE),
    .busy_o         (seq_busy),
    .done_o         (PULSE_DONE),
    .dec_o          (seq_dec)
  );

  always_comb begin
    ovr_d = ovr_q;
    if (seq_abort)                                   ovr_d = 1'b0;
    else if (wr_hit && !clr_hit && pc_sel && seq_busy) ovr_d = 1'b1;
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) ovr_q <= 1'b0;
    else         ovr_q <= ovr_d;
  end

  assign PULSE_BUSY = seq_busy;
  assign PULSE_OVR  = ovr_q;
`else
  assign seq_busy   = 1'b0;
  assign seq_dec    = 1'b0;
  assign PULSE      = 1'b0;
  assign PULSE_BUSY = 1'b0;
  assign PULSE_DONE = 1'b0;
  assign PULSE_OVR  = 1'b0;
`endif

endmodule

// File: tb/tb_io_channel_bank.sv
module tb_io_channel_bank;

  localparam int NCHAN = 4;
  localparam int WIDTH = 15;
  localparam int ADDRW = 9;
  localparam int BASE  = 'o13;
  localparam int PCH   = 1;
  localparam int PDIV  = 2;

  logic                   SIM_CLK = 1'b0;
  logic                   SIM_RST;
  logic                   GOJAM;
  logic [ADDRW-1:0]       CHADDR;
  logic                   RCHG, WCHG, CCHG;
  logic [WIDTH-1:0]       WL;
  logic [NCHAN*WIDTH-1:0] CHIN;
  logic [WIDTH-1:0]       CH;
  logic                   CH_VALID;
  logic [NCHAN*WIDTH-1:0] CHOUT;
  logic                   PULSE, PULSE_BUSY, PULSE_DONE, PULSE_OVR;

  int total = 0;
  int bad   = 0;
  int m [NCHAN];

  always #5 SIM_CLK = ~SIM_CLK;

  io_channel_bank #(
    .NCHAN(NCHAN), .WIDTH(WIDTH), .ADDRW(ADDRW), .BASE_ADDR(BASE),
    .PULSE_CHAN(PCH), .PULSE_DIV(PDIV)
  ) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .GOJAM(GOJAM), .CHADDR(CHADDR),
    .RCHG(RCHG), .WCHG(WCHG), .CCHG(CCHG), .WL(WL), .CHIN(CHIN),
    .CH(CH), .CH_VALID(CH_VALID), .CHOUT(CHOUT), .PULSE(PULSE),
    .PULSE_BUSY(PULSE_BUSY), .PULSE_DONE(PULSE_DONE), .PULSE_OVR(PULSE_OVR)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCHAN*WIDTH-1:0] model_chout();
    logic [NCHAN*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NCHAN; i++) r[i*WIDTH +: WIDTH] = WIDTH'(m[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic wr(input logic [ADDRW-1:0] a, input logic [WIDTH-1:0] d);
    CHADDR = a; WL = d; WCHG = 1'b1;
    tick();
    WCHG = 1'b0;
  endtask

  task automatic clr(input logic [ADDRW-1:0] a);
    CHADDR = a; CCHG = 1'b1;
    tick();
    CCHG = 1'b0;
  endtask

  task automatic rd(input logic [ADDRW-1:0] a);
    CHADDR = a; RCHG = 1'b1;
    tick();
    RCHG = 1'b0;
  endtask

  initial begin
    logic [ADDRW-1:0] addr_tab [6];
    logic [ADDRW-1:0] a;
    logic [WIDTH-1:0] exp_ch;
    logic             exp_v;
    int               idx;
    bit               hit;

    addr_tab = '{9'o13, 9'o15, 9'o16, 9'o12, 9'o17, 9'o20};
    SIM_RST = 1'b1; GOJAM = 1'b0; RCHG = 1'b0; WCHG = 1'b0; CCHG = 1'b0;
    CHADDR = '0; WL = '0; CHIN = '0;
    for (int i = 0; i < NCHAN; i++) m[i] = 0;

    // ---------------- reset state
    #2;
    check("rst_ch",    64'(CH), 64'(0));
    check("rst_vld",   64'(CH_VALID), 64'(0));
    check("rst_chout", 64'(CHOUT), 64'(0));
    check("rst_pulse", 64'(PULSE), 64'(0));
    check("rst_busy",  64'(PULSE_BUSY), 64'(0));
    check("rst_done",  64'(PULSE_DONE), 64'(0));
    check("rst_ovr",   64'(PULSE_OVR), 64'(0));
    tick(); tick();
    SIM_RST = 1'b0;
    tick();

    // ---------------- write + OR-read on idx 1
    CHIN = '0;
    CHIN[PCH*WIDTH +: WIDTH] = 15'o00002;
    wr(9'o14, 15'o12345); m[1] = 'o12345;
    check("wr_chout", 64'(CHOUT), 64'(model_chout()));
`ifdef IOBANK_PULSE_EN
    check("wr_starts_busy", 64'(PULSE_BUSY), 64'(1));
`endif
    rd(9'o14);
    check("rd_or_ch",  64'(CH), 64'(15'o12347));
    check("rd_or_vld", 64'(CH_VALID), 64'(1));
    tick();
    check("rd_vld_one_cycle", 64'(CH_VALID), 64'(0));
    check("rd_ch_one_cycle",  64'(CH), 64'(0));
    clr(9'o14); m[1] = 0;
    check("clr_chout", 64'(CHOUT), 64'(model_chout()));
    check("clr_busy",  64'(PULSE_BUSY), 64'(0));
    CHIN = '0;

    // ---------------- fill other channels, misses, boundaries
    wr(9'o13, 15'o11111); m[0] = 'o11111;
    wr(9'o15, 15'o22222); m[2] = 'o22222;
    wr(9'o16, 15'o33333); m[3] = 'o33333;
    check("fill_chout", 64'(CHOUT), 64'(model_chout()));
    CHADDR = 9'o20; WL = 15'o7777; WCHG = 1'b1; RCHG = 1'b1;
    tick();
    WCHG = 1'b0; RCHG = 1'b0;
    check("miss_vld",   64'(CH_VALID), 64'(0));
    check("miss_ch",    64'(CH), 64'(0));
    check("miss_chout", 64'(CHOUT), 64'(model_chout()));
    rd(9'o16);
    check("top_addr_rd", 64'(CH), 64'(15'o33333));
    rd(9'o12);
    check("below_base_vld", 64'(CH_VALID), 64'(0));
    CHADDR = 9'o15; WL = 15'o5555; WCHG = 1'b1; RCHG = 1'b1;
    tick();
    WCHG = 1'b0; RCHG = 1'b0; m[2] = 'o5555;
    check("rd_pre_write_ch",  64'(CH), 64'(15'o22222));
    check("rd_pre_write_vld", 64'(CH_VALID), 64'(1));
    check("rd_pre_write_chout", 64'(CHOUT), 64'(model_chout()));
    CHADDR = 9'o13; WL = 15'o7; WCHG = 1'b1; CCHG = 1'b1;
    tick();
    WCHG = 1'b0; CCHG = 1'b0; m[0] = 0;
    check("clr_beats_wr", 64'(CHOUT), 64'(model_chout()));
    CHADDR = 9'o16; WL = 15'o1; WCHG = 1'b1; GOJAM = 1'b1;
    tick();
    WCHG = 1'b0; GOJAM = 1'b0;
    for (int i = 0; i < NCHAN; i++) m[i] = 0;
    check("gojam_all_zero", 64'(CHOUT), 64'(0));

    // ---------------- pulse channel behaviour
`ifdef IOBANK_PULSE_EN
    wr(9'o14, 15'd3);
    for (int k = 0; k < 2 * PDIV * 3; k++) begin
      check("train_pulse", 64'(PULSE), 64'(((k / PDIV) % 2) == 0));
      check("train_busy",  64'(PULSE_BUSY), 64'(1));
      check("train_done",  64'(PULSE_DONE), 64'(0));
      check("train_count", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(3 - k / (2 * PDIV)));
      if (k % 4 == 2) begin
        check("train_rd_ch",  64'(CH), 64'(3 - (k - 1) / (2 * PDIV)));
        check("train_rd_vld", 64'(CH_VALID), 64'(1));
      end
      CHADDR = 9'o14;
      RCHG = (k % 4 == 1);
      tick();
    end
    RCHG = 1'b0;
    check("end_busy",  64'(PULSE_BUSY), 64'(0));
    check("end_done",  64'(PULSE_DONE), 64'(1));
    check("end_pulse", 64'(PULSE), 64'(0));
    check("end_count", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(0));
    wr(9'o14, 15'd2);
    check("b2b_busy",  64'(PULSE_BUSY), 64'(1));
    check("b2b_pulse", 64'(PULSE), 64'(1));
    check("b2b_done",  64'(PULSE_DONE), 64'(0));
    check("b2b_count", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(2));
    wr(9'o14, 15'd5);
    check("ovr_set",   64'(PULSE_OVR), 64'(1));
    check("ovr_count", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(2));
    check("ovr_busy",  64'(PULSE_BUSY), 64'(1));
    clr(9'o14);
    check("abort_pulse", 64'(PULSE), 64'(0));
    check("abort_busy",  64'(PULSE_BUSY), 64'(0));
    check("abort_ovr",   64'(PULSE_OVR), 64'(0));
    check("abort_done",  64'(PULSE_DONE), 64'(0));
    check("abort_count", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("after_abort_done", 64'(PULSE_DONE), 64'(0));
    end
    wr(9'o14, 15'd0);
    check("zero_wr_busy", 64'(PULSE_BUSY), 64'(0));
    tick();
    check("zero_wr_done", 64'(PULSE_DONE), 64'(0));
    wr(9'o14, 15'd3);
    check("pre_rst_pulse", 64'(PULSE), 64'(1));
    SIM_RST = 1'b1;
    #2;
    check("async_rst_pulse", 64'(PULSE), 64'(0));
    check("async_rst_busy",  64'(PULSE_BUSY), 64'(0));
    check("async_rst_chout", 64'(CHOUT), 64'(0));
`else
    wr(9'o14, 15'd3);
    for (int k = 0; k < 8; k++) begin
      check("plain_pulse", 64'(PULSE), 64'(0));
      check("plain_busy",  64'(PULSE_BUSY), 64'(0));
      check("plain_done",  64'(PULSE_DONE), 64'(0));
      check("plain_count", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(3));
      tick();
    end
    wr(9'o14, 15'd5);
    check("plain_rewrite", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(5));
    check("plain_ovr",     64'(PULSE_OVR), 64'(0));
    clr(9'o14);
    check("plain_clear", 64'(CHOUT[PCH*WIDTH +: WIDTH]), 64'(0));
    wr(9'o14, 15'd3);
    SIM_RST = 1'b1;
    #2;
    check("async_rst_pulse", 64'(PULSE), 64'(0));
    check("async_rst_chout", 64'(CHOUT), 64'(0));
`endif
    tick();
    SIM_RST = 1'b0;
    tick();
    for (int i = 0; i < NCHAN; i++) m[i] = 0;

    // ---------------- randomized traffic on the plain channels
    for (int n = 0; n < 200; n++) begin
      a      = addr_tab[$urandom_range(0, 5)];
      CHADDR = a;
      WL     = WIDTH'($urandom);
      CHIN   = (NCHAN*WIDTH)'({$urandom, $urandom});
      GOJAM  = ($urandom_range(0, 24) == 0);
      WCHG   = 1'($urandom_range(0, 1));
      CCHG   = ($urandom_range(0, 3) == 0);
      RCHG   = GOJAM ? 1'b0 : 1'($urandom_range(0, 1));
      hit    = (int'(a) >= BASE) && (int'(a) < BASE + NCHAN);
      idx    = int'(a) - BASE;
      exp_ch = '0;
      exp_v  = 1'b0;
      if (RCHG && hit) begin
        exp_ch = WIDTH'(m[idx]) | CHIN[idx*WIDTH +: WIDTH];
        exp_v  = 1'b1;
      end
      if (GOJAM) begin
        for (int i = 0; i < NCHAN; i++) m[i] = 0;
      end else if (CCHG && hit) begin
        m[idx] = 0;
      end else if (WCHG && hit) begin
        m[idx] = int'(WL);
      end
      tick();
      check("rand_ch",    64'(CH), 64'(exp_ch));
      check("rand_vld",   64'(CH_VALID), 64'(exp_v));
      check("rand_chout", 64'(CHOUT), 64'(model_chout()));
    end
    GOJAM = 1'b0; WCHG = 1'b0; CCHG = 1'b0; RCHG = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
